// File: rtl/button_debouncer_pkg.sv
// Shared constants for the button/switch conditioning front end.
package button_debouncer_pkg;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned NUM_SW  = 4;

  localparam int unsigned BTN_EAST   = 0;
  localparam int unsigned BTN_WEST   = 1;
  localparam int unsigned BTN_NORTH  = 2;
  localparam int unsigned BTN_SOUTH  = 3;
  localparam int unsigned BTN_CHANGE = 4;
endpackage

// File: rtl/button_debouncer_if.sv
// Raw board inputs and conditioned outputs of the debouncer.
interface button_debouncer_if;
  import button_debouncer_pkg::*;

  logic East, West, North, South, change_button;
  logic SW0, SW1, SW2, SW3;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_pulse;
  logic [NUM_SW-1:0]  sw_level;

  modport master (
    output East, West, North, South, change_button, SW0, SW1, SW2, SW3,
    input  btn_level, btn_pulse, sw_level
  );
  modport slave (
    input  East, West, North, South, change_button, SW0, SW1, SW2, SW3,
    output btn_level, btn_pulse, sw_level
  );
endinterface

// File: rtl/button_debouncer_channel.sv
// One channel: 2-flop synchroniser, stability counter, debounced level and
// optional rising-edge pulse.
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19,
  parameter bit          HAS_PULSE       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample matching the stable level discards the partial count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = s2_q;
      else                   cnt_d    = cnt_q + CNT_W'(1);
    end
    pulse_d = HAS_PULSE && !stable_q && stable_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;
  assign pulse_o = pulse_q;
endmodule

// File: rtl/button_debouncer.sv
// Synchronises and debounces the board buttons and switches; buttons also
// get a one-cycle pulse per debounced press.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 19
) (
  input logic               clk,
  input logic               reset,
  button_debouncer_if.slave bus
);
  logic [NUM_BTN-1:0] raw_btn;
  logic [NUM_SW-1:0]  raw_sw;
  logic [NUM_SW-1:0]  sw_pulse_unused;

  assign raw_btn[BTN_EAST]   = bus.East;
  assign raw_btn[BTN_WEST]   = bus.West;
  assign raw_btn[BTN_NORTH]  = bus.North;
  assign raw_btn[BTN_SOUTH]  = bus.South;
  assign raw_btn[BTN_CHANGE] = bus.change_button;
  assign raw_sw = {bus.SW3, bus.SW2, bus.SW1, bus.SW0};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .HAS_PULSE(1'b1)
    ) u_ch (
      .clk(clk), .reset(reset), .raw_i(raw_btn[i]),
      .level_o(bus.btn_level[i]), .pulse_o(bus.btn_pulse[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .HAS_PULSE(1'b0)
    ) u_ch (
      .clk(clk), .reset(reset), .raw_i(raw_sw[i]),
      .level_o(bus.sw_level[i]), .pulse_o(sw_pulse_unused[i])
    );
  end
endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with a short debounce window.
module tb_button_debouncer;
  localparam int D = 4;
  localparam int NCH = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  button_debouncer_if bus();

  button_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: a level flips once the last D synchronised samples all differ from it.
  logic [NCH-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
  logic [4:0]     m_pls = '0;
  bit             win[NCH][$];

  task automatic model_edge(input logic r, input logic [NCH-1:0] raw);
    logic [NCH-1:0] nl;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pls = '0;
      for (int c = 0; c < NCH; c++) win[c].delete();
    end else begin
      nl = m_lvl;
      for (int c = 0; c < NCH; c++) begin
        bit all_diff;
        win[c].push_back(m_s2[c]);
        if (win[c].size() > D) void'(win[c].pop_front());
        all_diff = (win[c].size() == D);
        foreach (win[c][j]) if (win[c][j] == m_lvl[c]) all_diff = 0;
        if (all_diff) nl[c] = ~m_lvl[c];
      end
      m_pls = nl[4:0] & ~m_lvl[4:0];
      m_lvl = nl;
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [NCH-1:0] raw);
    rst = r;
    {bus.SW3, bus.SW2, bus.SW1, bus.SW0, bus.change_button,
     bus.South, bus.North, bus.West, bus.East} = raw;
    model_edge(r, raw);
    @(posedge clk);
    @(negedge clk);
    chk("model_level", {bus.sw_level, bus.btn_level}, 32'(m_lvl));
    chk("model_pulse", bus.btn_pulse, 32'(m_pls));
  endtask

  typedef struct {
    logic           rst;
    logic [NCH-1:0] raw;
    logic [4:0]     lvl;
    logic [4:0]     pls;
    logic [3:0]     sw;
  } vec_t;
  vec_t tbl[17];

  initial begin
    int pstep, pcnt;
    int mode;
    logic [NCH-1:0] raw;

    // reset with all inputs high, then clean East press and release
    tbl[0]  = '{1'b1, 9'h1FF, 5'h00, 5'h00, 4'h0};
    tbl[1]  = '{1'b1, 9'h1FF, 5'h00, 5'h00, 4'h0};
    for (int i = 2; i <= 6; i++) tbl[i] = '{1'b0, 9'h001, 5'h00, 5'h00, 4'h0};
    tbl[7]  = '{1'b0, 9'h001, 5'h01, 5'h01, 4'h0};
    tbl[8]  = '{1'b0, 9'h001, 5'h01, 5'h00, 4'h0};
    tbl[9]  = '{1'b0, 9'h001, 5'h01, 5'h00, 4'h0};
    for (int i = 10; i <= 14; i++) tbl[i] = '{1'b0, 9'h000, 5'h01, 5'h00, 4'h0};
    tbl[15] = '{1'b0, 9'h000, 5'h00, 5'h00, 4'h0};
    tbl[16] = '{1'b0, 9'h000, 5'h00, 5'h00, 4'h0};

    {bus.SW3, bus.SW2, bus.SW1, bus.SW0, bus.change_button,
     bus.South, bus.North, bus.West, bus.East} = '0;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].raw);
      chk($sformatf("tbl%0d_btn_level", i), bus.btn_level, 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_btn_pulse", i), bus.btn_pulse, 32'(tbl[i].pls));
      chk($sformatf("tbl%0d_sw_level", i), bus.sw_level, 32'(tbl[i].sw));
    end

    // short bounce on change_button must be rejected
    for (int i = 0; i < 11; i++) begin
      step(1'b0, (i < 3) ? 9'h010 : 9'h000);
      chk("bounce_reject_level", bus.btn_level[4], 32'd0);
      chk("bounce_reject_pulse", bus.btn_pulse[4], 32'd0);
    end
    // 3 high, 1 low, then held: one pulse 5 edges after final rise
    pstep = -1; pcnt = 0;
    for (int i = 0; i < 13; i++) begin
      step(1'b0, (i == 3) ? 9'h000 : 9'h010);
      if (bus.btn_pulse[4]) begin
        pcnt++; pstep = i;
        chk("bounce_pulse_with_level", bus.btn_level[4], 32'd1);
      end
    end
    chk("bounce_pulse_count", pcnt, 32'd1);
    chk("bounce_pulse_step", pstep, 32'd9);
    chk("bounce_level_held", bus.btn_level[4], 32'd1);

    // simultaneous North, South, SW2
    step(1'b1, 9'h000);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 9'h08C);
      if (i == 4) chk("simul_before", {bus.sw_level, bus.btn_level, bus.btn_pulse}, 32'd0);
      if (i == 5) begin
        chk("simul_btn_level", bus.btn_level, 32'h0C);
        chk("simul_btn_pulse", bus.btn_pulse, 32'h0C);
        chk("simul_sw_level", bus.sw_level, 32'h4);
      end
      if (i == 6) chk("simul_pulse_gone", bus.btn_pulse, 32'h00);
    end

    // reset asserted mid-count restarts the debounce
    step(1'b1, 9'h000);
    for (int i = 0; i < 11; i++) begin
      step(i == 3, 9'h001);
      if (i <= 8) chk("rstmid_level_low", bus.btn_level[0], 32'd0);
      if (i == 9) begin
        chk("rstmid_level_rise", bus.btn_level[0], 32'd1);
        chk("rstmid_pulse", bus.btn_pulse[0], 32'd1);
      end
      if (i == 10) chk("rstmid_pulse_once", bus.btn_pulse[0], 32'd0);
    end

    // random bouncing against the reference model
    raw = '0;
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) mode = $urandom_range(0, 2);
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, (mode == 0) ? 2 : (mode == 1) ? 7 : 19) == 0) raw[c] = ~raw[c];
      step($urandom_range(0, 499) == 0, raw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
